gamma_lut_loader: RTL and testbench

//   Run-time LUT reload controller for the gamma corrector. Accepts a request to rewrite one

---
 rtl/gamma_lut_loader.sv | 176 +++++++++++++++++
 tb/tb_gamma_lut_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_lut_loader.sv
// gamma_lut_loader
//   Run-time reload controller for one colour plane's gamma LUT. A reload puts
//   the gamma core into bypass at a frame boundary and waits for its pipeline
//   to drain. It then streams 2**DATA_WIDTH entries into the selected plane's
//   LUT write port. Correction is re-enabled only at the next frame boundary,
//   so no frame is ever processed with a partially written table.
//
// Ports
//   clk, rstn        clock and synchronous active-low reset
//   load_req/load_cp one-cycle reload request and its target plane
//   abort            cancel an in-progress reload
//   frame_start      one-cycle pulse at each frame boundary
//   wr_valid/wr_data LUT entry source, ascending address order
//   wr_ready         loader accepts wr_data (registered)
//   gcen             gamma core enable, 0 = bypass
//   lut_wren/lut_val per-plane LUT write enable (one-hot or zero) and value
//   busy, done, err  status: reload in progress, completion pulse, error pulse
module gamma_lut_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CP     = 3,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_req,
  input  logic [1:0]            load_cp,
  input  logic                  abort,
  input  logic                  frame_start,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  gcen,
  output logic [NUM_CP-1:0]     lut_wren,
  output logic [DATA_WIDTH-1:0] lut_val,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DRW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int CW  = DATA_WIDTH + 1;
  // Index of the final entry; the counter has one spare bit so it never wraps.
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << DATA_WIDTH) - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OFF,
    DRAIN,
    LOAD,
    WAIT_ON
  } state_t;

  state_t                  state, state_d;
  logic [1:0]              cp, cp_d;
  logic [DRW-1:0]          drain, drain_d;
  logic [CW-1:0]           count, count_d;
  logic                    gcen_d, busy_d, done_d, err_d, wr_ready_d;
  logic [NUM_CP-1:0]       lut_wren_d;
  logic [DATA_WIDTH-1:0]   lut_val_d;
  logic                    xfer;

  assign xfer = wr_valid && wr_ready;

  // NOTE: every variable is given a default before the case statement, so a
  // path that does not assign it cannot infer a latch.
  always_comb begin
    state_d    = state;
    cp_d       = cp;
    drain_d    = drain;
    count_d    = count;
    gcen_d     = gcen;
    busy_d     = busy;
    wr_ready_d = wr_ready;
    lut_val_d  = lut_val;
    lut_wren_d = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // Abort beats frame_start and transfers. gcen is left alone on purpose:
    // a partially written LUT stays bypassed until a full reload.
    if (abort && state != IDLE) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      wr_ready_d = 1'b0;
      err_d      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load_req) begin
            if (32'(load_cp) < NUM_CP) begin
              cp_d    = load_cp;
              count_d = '0;
              busy_d  = 1'b1;
              state_d = WAIT_OFF;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WAIT_OFF: begin
          if (frame_start) begin
            gcen_d  = 1'b0;
            drain_d = DRW'(LATENCY);
            if (LATENCY == 0) begin
              state_d    = LOAD;
              wr_ready_d = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          // The state lasts exactly LATENCY cycles (drain = LATENCY down to 1).
          if (drain <= DRW'(1)) begin
            drain_d    = '0;
            state_d    = LOAD;
            wr_ready_d = 1'b1;
          end else begin
            drain_d = drain - DRW'(1);
          end
        end
        LOAD: begin
          if (xfer) begin
            for (int i = 0; i < NUM_CP; i++) lut_wren_d[i] = (32'(cp) == i);
            lut_val_d = wr_data;
            count_d   = count + CW'(1);
            if (count == LAST_IDX) begin
              wr_ready_d = 1'b0;
              state_d    = WAIT_ON;
            end
          end
        end
        WAIT_ON: begin
          if (frame_start) begin
            gcen_d  = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cp       <= '0;
      drain    <= '0;
      count    <= '0;
      gcen     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_ready <= 1'b0;
      lut_wren <= '0;
      lut_val  <= '0;
    end else begin
      state    <= state_d;
      cp       <= cp_d;
      drain    <= drain_d;
      count    <= count_d;
      gcen     <= gcen_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      wr_ready <= wr_ready_d;
      lut_wren <= lut_wren_d;
      lut_val  <= lut_val_d;
    end
  end

endmodule

// File: tb/tb_gamma_lut_loader.sv
// tb_gamma_lut_loader
//   Self-checking bench for gamma_lut_loader. The stimulus pushes one expected
//   LUT write (plane, value) per accepted entry into a scoreboard queue. A
//   negedge monitor pops and compares every write the DUT issues. Control
//   outputs (gcen, busy, done, err, wr_ready) are checked in the sequence
//   against a small model of the reload rules.
module tb_gamma_lut_loader;

  localparam int DW    = 8;
  localparam int NCP   = 3;
  localparam int LAT   = 4;
  localparam int DEPTH = 1 << DW;

  logic           clk;
  logic           rstn;
  logic           load_req;
  logic [1:0]     load_cp;
  logic           abort;
  logic           frame_start;
  logic           wr_valid;
  logic [DW-1:0]  wr_data;
  logic           wr_ready;
  logic           gcen;
  logic [NCP-1:0] lut_wren;
  logic [DW-1:0]  lut_val;
  logic           busy;
  logic           done;
  logic           err;

  gamma_lut_loader #(.DATA_WIDTH(DW), .NUM_CP(NCP), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_req   (load_req),
    .load_cp    (load_cp),
    .abort      (abort),
    .frame_start(frame_start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .gcen       (gcen),
    .lut_wren   (lut_wren),
    .lut_val    (lut_val),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCP-1:0] wren;
    logic [DW-1:0]  val;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks      = 0;
  int   errors      = 0;
  int   writes_seen = 0;
  bit   mon_en      = 0;
  logic exp_gcen    = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every LUT write must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en && lut_wren !== '0) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(lut_wren), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_plane", 32'(lut_wren), 32'(mon_e.wren));
        check("write_value", 32'(lut_val), 32'(mon_e.val));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int p);
    load_req = 1'b1;
    load_cp  = 2'(p);
    tick();
    load_req = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_gcen", 32'(gcen), 32'(exp_gcen));
  endtask

  // Frame boundary in WAIT_OFF, then count the bypass cycles before wr_ready.
  task automatic enter_load();
    int n;
    repeat ($urandom_range(0, 3)) tick();
    check("wait_off_gcen", 32'(gcen), 32'(exp_gcen));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_gcen = 1'b0;
    check("bypass_gcen", 32'(gcen), 32'd0);
    n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    check("drain_cycles", 32'(n), 32'(LAT));
  endtask

  // Streams entries until stop_at transfers are made. extras adds a
  // frame_start and a stray load_req in the middle of the stream.
  task automatic stream(input int p, input bit gaps, input bit idx_data,
                        input int stop_at, input bit extras);
    int   idx;
    int   cyc;
    wr_t  e;
    logic [DW-1:0] d;
    idx = 0;
    cyc = 0;
    while (idx < stop_at && cyc < 8 * DEPTH) begin
      wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d        = idx_data ? DW'(idx) : DW'($urandom);
      wr_data  = wr_valid ? d : DW'($urandom);
      if (extras && cyc == 60) frame_start = 1'b1;
      if (extras && cyc == 130) begin
        load_req = 1'b1;
        load_cp  = 2'd0;
      end
      if (wr_valid && wr_ready) begin
        e.wren = NCP'(1) << p;
        e.val  = d;
        exp_q.push_back(e);
        idx++;
      end
      tick();
      if (extras && (cyc == 60 || cyc == 130)) begin
        check("mid_load_gcen", 32'(gcen), 32'd0);
        check("mid_load_busy", 32'(busy), 32'd1);
      end
      frame_start = 1'b0;
      load_req    = 1'b0;
      cyc++;
    end
    wr_valid = 1'b0;
    check("stream_complete", 32'(idx), 32'(stop_at));
  endtask

  task automatic finish_load(input int writes_before);
    check("last_ready_low", 32'(wr_ready), 32'd0);
    repeat (3) begin
      tick();
      check("wait_on_gcen", 32'(gcen), 32'd0);
      check("wait_on_done", 32'(done), 32'd0);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_gcen = 1'b1;
    check("done_pulse", 32'(done), 32'd1);
    check("done_gcen", 32'(gcen), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(writes_seen - writes_before), 32'(DEPTH));
  endtask

  task automatic full_reload(input int p, input bit gaps, input bit idx_data, input bit extras);
    int w0;
    w0 = writes_seen;
    start_load(p);
    enter_load();
    stream(p, gaps, idx_data, DEPTH, extras);
    finish_load(w0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gcen"}, 32'(gcen), 32'(exp_gcen));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(wr_ready), 32'd0);
    check({tag, "_wren"}, 32'(lut_wren), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int w0;
    rstn        = 1'b0;
    load_req    = 1'b0;
    load_cp     = 2'd0;
    abort       = 1'b0;
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    tick();
    tick();
    mon_en = 1'b1;
    check_idle_outputs("reset");
    check("reset_err", 32'(err), 32'd0);
    check("reset_val", 32'(lut_val), 32'd0);
    rstn = 1'b1;

    // Idle with frame boundaries: nothing changes.
    for (int i = 0; i < 20; i++) begin
      frame_start = (i % 5 == 0);
      tick();
      check_idle_outputs("idle");
    end
    frame_start = 1'b0;

    // Full reload, plane 1, continuous valid, values 0..255.
    full_reload(1, 1'b0, 1'b1, 1'b0);

    // Random gaps, random data, frame_start and load_req during LOAD.
    full_reload(1, 1'b1, 1'b0, 1'b1);
    full_reload(0, 1'b1, 1'b0, 1'b0);

    // Out-of-range plane.
    w0 = writes_seen;
    load_req = 1'b1;
    load_cp  = 2'd3;
    tick();
    load_req = 1'b0;
    check("bad_cp_err", 32'(err), 32'd1);
    check("bad_cp_busy", 32'(busy), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("bad_cp_err_pulse", 32'(err), 32'd0);
    repeat (10) tick();
    check_idle_outputs("bad_cp");
    check("bad_cp_no_writes", 32'(writes_seen - w0), 32'd0);

    // abort in IDLE is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_err", 32'(err), 32'd0);

    // abort after 100 writes.
    w0 = writes_seen;
    start_load(2);
    enter_load();
    stream(2, 1'b1, 1'b0, 100, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_err", 32'(err), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(wr_ready), 32'd0);
    check("abort_gcen", 32'(gcen), 32'd0);
    check("abort_wren", 32'(lut_wren), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("abort_err_pulse", 32'(err), 32'd0);
    check("abort_gcen_held", 32'(gcen), 32'd0);
    check("abort_write_count", 32'(writes_seen - w0), 32'd100);
    check("abort_queue", 32'(exp_q.size()), 32'd0);

    // A full reload after the abort restores correction.
    full_reload(2, 1'b1, 1'b1, 1'b0);

    // abort in WAIT_OFF leaves gcen at 1.
    start_load(0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wait_off_abort_err", 32'(err), 32'd1);
    check("wait_off_abort_busy", 32'(busy), 32'd0);
    check("wait_off_abort_gcen", 32'(gcen), 32'd1);

    // Reset mid-LOAD, then a reload must issue a complete table again.
    start_load(1);
    enter_load();
    stream(1, 1'b1, 1'b1, 50, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_gcen = 1'b1;
    check_idle_outputs("mid_reset");
    check("mid_reset_err", 32'(err), 32'd0);
    check("mid_reset_queue", 32'(exp_q.size()), 32'd0);
    tick();
    full_reload(1, 1'b0, 1'b1, 1'b0);

    repeat (5) tick();
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
